seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive side of the two-digit 7-segment display path: samples a time-multiplexed segment bus (segment pattern plus one-hot digit select) driven by an external display driver.
- Decodes each stable pattern back to a BCD digit and holds the reconstructed 2-digit value {tens, ones}.
- Mirrors that value on the LED bank, flags undecodable patterns, and pulses when the value changes.
- Used to loop back and check display output in lab builds and benches.

Parameters:
- STABLE_CYCLES, 4, number of consecutive sampling edges a {seg, dig_sel} pair must remain unchanged before it is accepted; legal range 2..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- seg  input  7  segment pattern, active-high, bit order {g,f,e,d,c,b,a}
- dig_sel  input  2  one-hot digit select: 2'b10 = tens, 2'b01 = ones; 2'b00 or 2'b11 = blank, ignored
- bcd  output  8  reconstructed value, bcd[7:4] = tens, bcd[3:0] = ones
- led  output  8  combinational copy of bcd
- both_valid  output  1  high once both digits have been accepted with legal codes since reset
- err  output  2  err[1] = tens, err[0] = ones; set on an undecodable accepted pattern for that digit
- upd  output  1  one-cycle pulse when bcd changes value

Behaviour:
- Reset (async, rst=1):
  - bcd=8'h00, err=2'b00, both_valid=0, upd=0.
  - Stability counter cleared, FSM in WAIT, internal have-digit flags cleared.
- Legal decode table; any other 7-bit pattern is illegal:
  - 0=7'b0111111, 1=7'b0000110, 2=7'b1011011, 3=7'b1001111, 4=7'b1100110
  - 5=7'b1101101, 6=7'b1111101, 7=7'b0000111, 8=7'b1111111, 9=7'b1100111
- Stability filter:
  - {seg, dig_sel} is registered every edge.
  - If a new sample equals the previous one, the counter increments, saturating at STABLE_CYCLES-1. Otherwise the counter is 0 and the FSM returns to WAIT.
- FSM:
  - WAIT: when the counter reaches STABLE_CYCLES-1 (pair present on STABLE_CYCLES consecutive edges), go to ACCEPT.
  - ACCEPT: lasts one cycle; performs the update below; go to HOLD.
  - HOLD: no further accepts until the pair changes, then go to WAIT with counter 0.
- Latency: with a pair first present at edge 1 and held, outputs update at edge STABLE_CYCLES+1 (edge 5 at default).
- ACCEPT action for the selected digit (one-hot dig_sel only):
  - Legal code: write the digit into bcd, clear that err bit, set that have-flag. upd=1 on the same edge only if bcd actually changed.
  - Illegal code: bcd digit held, err bit set, have-flag unchanged, upd=0.
  - dig_sel 2'b00 or 2'b11: no state change besides the FSM.
- err bits are sticky per digit until a legal accept on that digit or reset.
- both_valid = have_tens & have_ones, registered; it does not drop on later errors.
- upd is high for exactly one cycle per changing accept; it is never asserted by reset.
- A glitch shorter than STABLE_CYCLES edges is never accepted and does not disturb the held values.
- Changing the select while keeping the pattern counts as a change.
- Reset asserted mid-count or in HOLD takes effect immediately. After release, the block waits for a full new stable window; a pair held across reset is re-accepted.

Test Plan:
- Reset, then seg=7'b1001111, dig_sel=2'b01 held 8 cycles -> bcd=8'h03 at edge 5, upd pulses once, both_valid=0, led=8'h03.
- Then seg=7'b1100111, dig_sel=2'b10 held -> bcd=8'h93, both_valid=1, upd one pulse. Re-present the same tens pattern after a select change -> bcd unchanged, upd stays 0.
- Tens pattern 7'b1011011 held only 3 cycles (STABLE_CYCLES=4), alternating with ones -> no accept, bcd held at 8'h93.
- Illegal ones pattern 7'b1110000 held -> err=2'b01, bcd=8'h93. Then legal 7'b0000110 -> err=2'b00, bcd=8'h91.
- Multiplexed scan at 6 cycles per digit showing "57" -> bcd=8'h57, settles with no further upd pulses.
- rst pulsed in HOLD with bcd=8'h57 -> all outputs cleared immediately; same pattern held -> re-accepted STABLE_CYCLES+1 edges after release.

Source files
------------

// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - segment bus and reconstructed-value signals
interface seg7_capture_if;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic [7:0] bcd;
  logic [7:0] led;
  logic       both_valid;
  logic [1:0] err;
  logic       upd;

  modport master (
    output seg, dig_sel,
    input  bcd, led, both_valid, err, upd
  );

  modport slave (
    input  seg, dig_sel,
    output bcd, led, both_valid, err, upd
  );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - stability-filtered 7-segment bus decoder to 2-digit BCD
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg7_capture_if.slave  bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACCEPT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [8:0] pair_d, pair_q;
  logic [7:0] cnt;
  logic       same;
  logic       accept;

  logic [3:0] tens, ones;
  logic [1:0] err;
  logic       have_tens, have_ones;
  logic       have_tens_n, have_ones_n;
  logic       both_valid;
  logic       upd;

  logic [6:0] seg_q;
  logic [1:0] sel_q;
  logic       legal;
  logic [3:0] digit;

  assign pair_d = {bus.seg, bus.dig_sel};
  assign same   = (pair_d == pair_q);
  assign seg_q  = pair_q[8:2];
  assign sel_q  = pair_q[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q <= 9'd0;
      cnt    <= 8'd0;
    end else begin
      pair_q <= pair_d;
      if (!same)
        cnt <= 8'd0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= WAIT;
    else
      state <= state_n;
  end

  // ACCEPT is entered on the edge the counter saturates, so the update lands one edge later
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      WAIT: begin
        if (same && (cnt == CNT_MAX - 8'd1))
          state_n = ACCEPT;
      end
      ACCEPT: begin
        accept  = 1'b1;
        state_n = same ? HOLD : WAIT;
      end
      HOLD: begin
        if (!same)
          state_n = WAIT;
      end
      default: state_n = WAIT;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (seg_q)
      7'b0111111: digit = 4'd0;
      7'b0000110: digit = 4'd1;
      7'b1011011: digit = 4'd2;
      7'b1001111: digit = 4'd3;
      7'b1100110: digit = 4'd4;
      7'b1101101: digit = 4'd5;
      7'b1111101: digit = 4'd6;
      7'b0000111: digit = 4'd7;
      7'b1111111: digit = 4'd8;
      7'b1100111: digit = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    have_tens_n = have_tens | (accept && legal && (sel_q == 2'b10));
    have_ones_n = have_ones | (accept && legal && (sel_q == 2'b01));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens       <= 4'd0;
      ones       <= 4'd0;
      err        <= 2'b00;
      have_tens  <= 1'b0;
      have_ones  <= 1'b0;
      both_valid <= 1'b0;
      upd        <= 1'b0;
    end else begin
      upd        <= 1'b0;
      have_tens  <= have_tens_n;
      have_ones  <= have_ones_n;
      both_valid <= have_tens_n & have_ones_n;
      if (accept) begin
        case (sel_q)
          2'b10: begin
            if (legal) begin
              tens   <= digit;
              err[1] <= 1'b0;
              upd    <= (tens != digit);
            end else begin
              err[1] <= 1'b1;
            end
          end
          2'b01: begin
            if (legal) begin
              ones   <= digit;
              err[0] <= 1'b0;
              upd    <= (ones != digit);
            end else begin
              err[0] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bcd        = {tens, ones};
  assign bus.led        = {tens, ones};
  assign bus.err        = err;
  assign bus.both_valid = both_valid;
  assign bus.upd        = upd;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - scoreboard bench for seg7_capture
module tb_seg7_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  seg7_capture_if bus ();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t [10];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};
    return t[d];
  endfunction

  // every upd pulse must match the next expected value change
  always @(negedge clk) begin
    if (!rst && bus.upd === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL upd_unexpected bcd=%h expected no pulse", bus.bcd);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.bcd !== e) begin
          failures++;
          $display("FAIL upd_value bcd=%h expected=%h", bus.bcd, e);
        end
      end
    end
  end

  task automatic hold(input logic [6:0] s, input logic [1:0] d, input int n);
    bus.seg = s;
    bus.dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    bus.seg = 7'd0;
    bus.dig_sel = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk8("reset_bcd", bus.bcd, 8'h00);
    chk8("reset_led", bus.led, 8'h00);
    chk8("reset_err", {6'd0, bus.err}, 8'h00);
    chk8("reset_both", {7'd0, bus.both_valid}, 8'h00);
    chk8("reset_upd", {7'd0, bus.upd}, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_first_ones;
    exp_q.push_back(8'h03);
    hold(enc(3), 2'b01, 4);
    chk8("latency_not_yet", bus.bcd, 8'h00);
    hold(enc(3), 2'b01, 1);
    chk8("ones_bcd", bus.bcd, 8'h03);
    chk8("ones_led", bus.led, 8'h03);
    chk8("ones_both", {7'd0, bus.both_valid}, 8'h00);
    hold(enc(3), 2'b01, 3);
  endtask

  task automatic test_tens;
    exp_q.push_back(8'h93);
    hold(enc(9), 2'b10, 5);
    chk8("tens_bcd", bus.bcd, 8'h93);
    chk8("tens_both", {7'd0, bus.both_valid}, 8'h01);
    hold(enc(9), 2'b10, 3);
    hold(enc(9), 2'b00, 6);
    hold(enc(9), 2'b10, 6);
    chk8("reaccept_same", bus.bcd, 8'h93);
  endtask

  task automatic test_glitch;
    for (int i = 0; i < 2; i++) begin
      hold(enc(2), 2'b10, 3);
      hold(enc(3), 2'b01, 6);
    end
    chk8("glitch_bcd", bus.bcd, 8'h93);
  endtask

  task automatic test_illegal;
    hold(7'b1110000, 2'b01, 6);
    chk8("illegal_err", {6'd0, bus.err}, 8'h01);
    chk8("illegal_bcd", bus.bcd, 8'h93);
    chk8("illegal_both", {7'd0, bus.both_valid}, 8'h01);
    exp_q.push_back(8'h91);
    hold(enc(1), 2'b01, 6);
    chk8("clear_err", {6'd0, bus.err}, 8'h00);
    chk8("clear_bcd", bus.bcd, 8'h91);
    hold(7'b0000000, 2'b10, 6);
    chk8("illegal_tens_err", {6'd0, bus.err}, 8'h02);
    hold(enc(9), 2'b10, 6);
    chk8("tens_err_cleared", {6'd0, bus.err}, 8'h00);
  endtask

  task automatic test_scan;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) exp_q.push_back(8'h51);
      hold(enc(5), 2'b10, 6);
      if (i == 0) exp_q.push_back(8'h57);
      hold(enc(7), 2'b01, 6);
    end
    chk8("scan_bcd", bus.bcd, 8'h57);
  endtask

  task automatic test_reset_in_hold;
    rst = 1'b1;
    #1;
    chk8("rst_hold_bcd", bus.bcd, 8'h00);
    chk8("rst_hold_led", bus.led, 8'h00);
    chk8("rst_hold_err", {6'd0, bus.err}, 8'h00);
    chk8("rst_hold_both", {7'd0, bus.both_valid}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h07);
    hold(enc(7), 2'b01, 4);
    chk8("rst_relatency", bus.bcd, 8'h00);
    hold(enc(7), 2'b01, 1);
    chk8("rst_reaccept", bus.bcd, 8'h07);
    hold(enc(7), 2'b01, 3);
  endtask

  initial begin
    test_reset();
    test_first_ones();
    test_tens();
    test_glitch();
    test_illegal();
    test_scan();
    test_reset_in_hold();
    chk8("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
